kernel_top_x_fifo: RTL and testbench
====================================

KERNEL_TOP_X_FIFO -- requirements
Module: kernel_top_x_fifo

Interface
REQ-001 Parameter STREAMW, default 32, data width in bits.
REQ-002 Parameter DEPTH, default 4, number of storage entries; SHALL be a power of 2 and >= 2.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-low reset (0 = reset); sampled only on the rising edge of clk.
REQ-005 ivalid_in1  input  1  upstream data valid.
REQ-006 in1  input  STREAMW  upstream data.
REQ-007 iready  output  1  this block can accept a word this cycle.
REQ-008 ovalid_out1  output  1  out1 holds a valid word.
REQ-009 out1  output  STREAMW  head-of-queue data.
REQ-010 oready_out1  input  1  downstream (delay buffer) accepts the word this cycle.
REQ-011 count  output  log2(DEPTH)+1  number of words held, 0..DEPTH.

Function
REQ-012 The block SHALL be a first-word-fall-through FIFO between an upstream stage and the latency-matching delay buffer.
REQ-013 Push SHALL occur on an edge where ivalid_in1=1 and iready=1; in1 written at the write pointer, which then increments.
REQ-014 Pop SHALL occur on an edge where ovalid_out1=1 and oready_out1=1; the read pointer then increments.
REQ-015 Both pointers SHALL wrap from DEPTH-1 to 0.
REQ-016 iready SHALL be 1 iff rst=1 and count<DEPTH; it SHALL depend only on registered state, with no combinational path from oready_out1.
REQ-017 ovalid_out1 SHALL be 1 iff count>0; it SHALL not depend combinationally on ivalid_in1.
REQ-018 out1 SHALL equal the entry at the read pointer, combinationally from registered storage.
REQ-019 Latency: a word pushed on edge N SHALL appear on out1 with ovalid_out1=1 in the cycle after edge N, provided the FIFO was empty before edge N.
REQ-020 count SHALL increment on push-only, decrement on pop-only, and hold on push+pop or idle.
REQ-021 Simultaneous push and pop with 0<count<DEPTH SHALL leave count unchanged, and ordering SHALL be preserved.
REQ-022 Full (count=DEPTH): iready=0; a pop on that edge SHALL NOT permit a same-edge push; iready SHALL return to 1 in the next cycle.
REQ-023 Empty (count=0): no pop is possible; a push SHALL NOT bypass to out1 in the same cycle.
REQ-024 While oready_out1=0 and ovalid_out1=1, out1 and ovalid_out1 SHALL remain stable until a pop occurs.
REQ-025 Data SHALL be delivered in strict arrival order, with no loss or duplication.
REQ-026 ivalid_in1 with iready=0 SHALL be ignored; upstream is required to hold the word.

Reset
REQ-027 On an edge with rst=0: pointers, count, and all storage entries SHALL be cleared to 0.
REQ-028 Outputs while rst=0 and in the first cycle after: ovalid_out1=0, out1=0, count=0; iready=0 while rst=0 and 1 once rst=1.
REQ-029 Reset asserted mid-operation SHALL discard all held words; no stale word SHALL reappear after rst returns to 1.
REQ-030 Pushes and pops requested on a reset edge SHALL be ignored.

Verification
REQ-031 Reset then single word: push 0xA5A5A5A5 with oready_out1=1 -> next cycle out1=0xA5A5A5A5, ovalid_out1=1, count=1; popped on the following edge, count=0.
REQ-032 Fill and backpressure: oready_out1=0, push 1,2,3,4 (DEPTH=4) -> count=4, iready=0; a 5th word presented is not accepted; out1=1 stable throughout.
REQ-033 Drain from full: raise oready_out1 -> out1 sequence 1,2,3,4 on consecutive cycles; iready=1 the cycle after the first pop; ovalid_out1=0 after the 4th pop.
REQ-034 Concurrent flow: count=2, push and pop every cycle for 10 cycles -> count stays 2; output sequence equals input sequence delayed by 2 words; pointers wrap at least twice.
REQ-035 Mid-operation reset: count=3, assert rst=0 for one edge -> count=0, ovalid_out1=0, out1=0; the next pushed word 0x77 is the first word popped.
REQ-036 Random valid/ready toggling for 10k cycles against a scoreboard -> zero ordering or data mismatches; count never exceeds DEPTH.

Source files
------------

// File: rtl/kernel_top_x_fifo_if.sv
// rtl/kernel_top_x_fifo_if.sv - stream handshake bundle between upstream, fifo and delay buffer
interface kernel_top_x_fifo_if #(
  parameter int STREAMW = 32,
  parameter int DEPTH   = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic               ivalid_in1;
  logic [STREAMW-1:0] in1;
  logic               iready;
  logic               ovalid_out1;
  logic [STREAMW-1:0] out1;
  logic               oready_out1;
  logic [CW-1:0]      count;

  // fifo side
  modport slave (
    input  ivalid_in1, in1, oready_out1,
    output iready, ovalid_out1, out1, count
  );

  // upstream/downstream environment side
  modport master (
    output ivalid_in1, in1, oready_out1,
    input  iready, ovalid_out1, out1, count
  );
endinterface

// File: rtl/kernel_top_x_fifo.sv
// rtl/kernel_top_x_fifo.sv - first-word-fall-through fifo feeding the latency-matching delay buffer
module kernel_top_x_fifo #(
  parameter int STREAMW = 32,
  parameter int DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst,
  kernel_top_x_fifo_if.slave  s
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [STREAMW-1:0] mem_q [DEPTH];
  logic [STREAMW-1:0] mem_d [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;

  logic iready;
  logic ovalid;
  logic push;
  logic pop;

  // iready looks only at stored count, so a pop on a full edge never frees a slot that same edge
  always_comb begin
    iready = rst && (count_q != FULL_CNT);
    ovalid = (count_q != '0);
    push   = s.ivalid_in1 && iready;
    pop    = ovalid && s.oready_out1;
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      mem_d[wr_ptr_q] = s.in1;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // storage is cleared too so out1 reads zero while empty after reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign s.iready      = iready;
  assign s.ovalid_out1 = ovalid;
  assign s.out1        = mem_q[rd_ptr_q];
  assign s.count       = count_q;
endmodule

// File: tb/tb_kernel_top_x_fifo.sv
// tb/tb_kernel_top_x_fifo.sv - scoreboard bench for kernel_top_x_fifo
module tb_kernel_top_x_fifo;
  localparam int W = 32;
  localparam int D = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  logic [W-1:0] sb[$];

  kernel_top_x_fifo_if #(.STREAMW(W), .DEPTH(D)) f();
  kernel_top_x_fifo #(.STREAMW(W), .DEPTH(D)) dut (.clk(clk), .rst(rst), .s(f));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic iv, input logic [W-1:0] d, input logic orr);
    f.ivalid_in1  = iv;
    f.in1         = d;
    f.oready_out1 = orr;
  endtask

  // advance one edge; the scoreboard follows the handshake the fifo is required to perform
  task automatic tick();
    bit push;
    bit pop;
    push = f.ivalid_in1 && rst && (sb.size() < D);
    pop  = f.oready_out1 && rst && (sb.size() > 0);
    if (!rst) sb.delete();
    else begin
      if (pop) void'(sb.pop_front());
      if (push) sb.push_back(f.in1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, 32'h1234, 1'b1);
    tick();
    tick();
    n_cmp++; if (f.iready !== 1'b0) begin n_bad++; $display("FAIL rst_iready: got %b want 0", f.iready); end
    n_cmp++; if (f.ovalid_out1 !== 1'b0) begin n_bad++; $display("FAIL rst_ovalid: got %b want 0", f.ovalid_out1); end
    n_cmp++; if (f.out1 !== 32'h0) begin n_bad++; $display("FAIL rst_out1: got %h want 0", f.out1); end
    n_cmp++; if (int'(f.count) !== 0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", f.count); end
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    #1;
    n_cmp++; if (f.iready !== 1'b1) begin n_bad++; $display("FAIL post_rst_iready: got %b want 1", f.iready); end
    n_cmp++; if (f.ovalid_out1 !== 1'b0 || f.out1 !== 32'h0) begin n_bad++; $display("FAIL post_rst_out: got %b/%h want 0/0", f.ovalid_out1, f.out1); end
  endtask

  task automatic test_single();
    drive(1'b1, 32'hA5A5A5A5, 1'b1);
    n_cmp++; if (f.ovalid_out1 !== 1'b0 || f.out1 !== 32'h0) begin n_bad++; $display("FAIL no_bypass: got %b/%h want 0/0", f.ovalid_out1, f.out1); end
    tick();
    drive(1'b0, 32'h0, 1'b1);
    n_cmp++; if (f.ovalid_out1 !== 1'b1) begin n_bad++; $display("FAIL single_ovalid: got %b want 1", f.ovalid_out1); end
    n_cmp++; if (sb.size() != 1 || f.out1 !== sb[0] || sb[0] !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL single_out1: got %h want a5a5a5a5", f.out1); end
    n_cmp++; if (int'(f.count) !== 1) begin n_bad++; $display("FAIL single_count: got %0d want 1", f.count); end
    tick();
    n_cmp++; if (int'(f.count) !== 0 || f.ovalid_out1 !== 1'b0) begin n_bad++; $display("FAIL single_pop: got count %0d ovalid %b want 0/0", f.count, f.ovalid_out1); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= D; i++) begin
      drive(1'b1, W'(i), 1'b0);
      tick();
      n_cmp++; if (f.out1 !== 32'd1) begin n_bad++; $display("FAIL fill_stable_%0d: got %h want 1", i, f.out1); end
    end
    n_cmp++; if (int'(f.count) !== D || f.iready !== 1'b0) begin n_bad++; $display("FAIL fill_full: got count %0d iready %b want %0d/0", f.count, f.iready, D); end
    drive(1'b1, 32'd5, 1'b0);
    tick();
    tick();
    n_cmp++; if (int'(f.count) !== D || f.out1 !== 32'd1 || f.ovalid_out1 !== 1'b1) begin n_bad++; $display("FAIL fill_5th: got count %0d out1 %h want %0d/1", f.count, f.out1, D); end
  endtask

  task automatic test_drain();
    logic [W-1:0] exp;
    for (int k = 0; k < D; k++) begin
      // on the first drain edge the fifo is full, so the offered word 99 must be refused
      drive(k == 0, 32'd99, 1'b1);
      exp = W'(k + 1);
      n_cmp++; if (f.ovalid_out1 !== 1'b1 || f.out1 !== exp || sb[0] !== exp) begin n_bad++; $display("FAIL drain_%0d: got %b/%h want 1/%h", k, f.ovalid_out1, f.out1, exp); end
      tick();
      if (k == 0) begin
        n_cmp++; if (f.iready !== 1'b1 || int'(f.count) !== D - 1) begin n_bad++; $display("FAIL drain_iready: got %b count %0d want 1/%0d", f.iready, f.count, D - 1); end
      end
    end
    drive(1'b0, 32'h0, 1'b1);
    n_cmp++; if (f.ovalid_out1 !== 1'b0 || int'(f.count) !== 0) begin n_bad++; $display("FAIL drain_empty: got %b count %0d want 0/0", f.ovalid_out1, f.count); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h100, 1'b0);
    tick();
    drive(1'b1, 32'h101, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, W'(32'h102 + i), 1'b1);
      n_cmp++; if (int'(f.count) !== 2) begin n_bad++; $display("FAIL b2b_count_%0d: got %0d want 2", i, f.count); end
      n_cmp++; if (f.out1 !== W'(32'h100 + i) || f.out1 !== sb[0]) begin n_bad++; $display("FAIL b2b_data_%0d: got %h want %h", i, f.out1, 32'h100 + i); end
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 32'h0, 1'b1);
      n_cmp++; if (f.out1 !== W'(32'h10A + i)) begin n_bad++; $display("FAIL b2b_tail_%0d: got %h want %h", i, f.out1, 32'h10A + i); end
      tick();
    end
    n_cmp++; if (f.ovalid_out1 !== 1'b0) begin n_bad++; $display("FAIL b2b_empty: got %b want 0", f.ovalid_out1); end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, W'(32'hC0 + i), 1'b0);
      tick();
    end
    n_cmp++; if (int'(f.count) !== 3) begin n_bad++; $display("FAIL mr_pre_count: got %0d want 3", f.count); end
    rst = 1'b0;
    drive(1'b1, 32'hDEAD, 1'b1);
    #1;
    n_cmp++; if (f.iready !== 1'b0) begin n_bad++; $display("FAIL mr_iready: got %b want 0", f.iready); end
    tick();
    rst = 1'b1;
    drive(1'b1, 32'h77, 1'b0);
    n_cmp++; if (int'(f.count) !== 0 || f.ovalid_out1 !== 1'b0 || f.out1 !== 32'h0) begin n_bad++; $display("FAIL mr_cleared: got count %0d ovalid %b out1 %h want 0/0/0", f.count, f.ovalid_out1, f.out1); end
    tick();
    drive(1'b0, 32'h0, 1'b1);
    n_cmp++; if (f.out1 !== 32'h77 || f.ovalid_out1 !== 1'b1 || int'(f.count) !== 1) begin n_bad++; $display("FAIL mr_first: got %h count %0d want 77/1", f.out1, f.count); end
    tick();
    n_cmp++; if (f.ovalid_out1 !== 1'b0) begin n_bad++; $display("FAIL mr_drained: got %b want 0", f.ovalid_out1); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 10000; c++) begin
      drive(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)));
      n_cmp++; if (int'(f.count) !== sb.size() || int'(f.count) > D) begin n_bad++; $display("FAIL rnd_count_%0d: got %0d want %0d", c, f.count, sb.size()); end
      n_cmp++; if (f.ovalid_out1 !== (sb.size() > 0) || f.iready !== (sb.size() < D)) begin n_bad++; $display("FAIL rnd_flags_%0d: got ov %b ir %b want size %0d", c, f.ovalid_out1, f.iready, sb.size()); end
      if (sb.size() > 0) begin
        n_cmp++; if (f.out1 !== sb[0]) begin n_bad++; $display("FAIL rnd_data_%0d: got %h want %h", c, f.out1, sb[0]); end
      end
      tick();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
